// File: rtl/crossy_pkg.sv
// Shared definitions for the crossy-road pipeline: game state encoding,
// screen geometry and small helpers used by the control and video stages.
package crossy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int FRAME_START_LINE = 480;

    // Frames after entering OVER during which a press cannot restart the game.
    localparam int OVER_GUARD_FRAMES = 16;

    function automatic logic is_dead_state(input game_state_t s);
        return (s == ST_DYING) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising edge of the filtered level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level; any bounce back to the old level reloads it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: IDLE/PLAY/DYING/OVER sequencing, per-frame hit
// latching, lives and best-score tracking, and the renderer flash flag.
module game_ctrl
    import crossy_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEATH_FRAMES    = 60,
    parameter int FLASH_SHIFT     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_btn,
    input  logic       frame_start,
    input  logic       collision,
    input  logic [7:0] score,
    output logic       move_pulse,
    output logic       game_rst,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [7:0] best_score,
    output logic       flash
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    game_state_t state_q, state_d;
    logic        press;
    logic        death;
    logic        hit_q, hit_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  best_q, best_d;
    logic        move_pulse_q, move_pulse_d;
    logic        game_rst_q, game_rst_d;
    logic        flash_q, flash_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_move_btn (
        .clk_i  (clk),
        .rst_i  (reset),
        .btn_i  (move_btn),
        .press_o(press)
    );

    // A hit is only acted on at the frame boundary, so mid-frame pixel
    // collisions collapse into one death per frame.
    assign death = (state_q == ST_PLAY) && frame_start && hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (death) state_d = (lives_q <= 2'd1) ? ST_OVER : ST_DYING;
            end
            ST_DYING: begin
                if (frame_start && (frame_cnt_q == 6'(DEATH_FRAMES - 1))) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (press && (frame_cnt_q >= 6'(OVER_GUARD_FRAMES))) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hit_d = 1'b0;
        if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
            // A collision coinciding with frame_start belongs to the next frame.
            hit_d = frame_start ? collision : (hit_q | collision);
        end

        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_start && (frame_cnt_q != 6'd63)) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
        end

        lives_d = lives_q;
        if (state_d == ST_IDLE) begin
            lives_d = LIVES_INIT;
        end else if (death) begin
            lives_d = lives_q - 2'd1;
        end

        best_d = best_q;
        if (death && (score > best_q)) best_d = score;

        move_pulse_d = press && (state_q == ST_PLAY) && !death;
        game_rst_d   = (state_d != ST_PLAY);
        flash_d      = is_dead_state(state_d) && frame_cnt_d[FLASH_SHIFT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q        <= 1'b0;
            frame_cnt_q  <= '0;
            lives_q      <= LIVES_INIT;
            best_q       <= '0;
            move_pulse_q <= 1'b0;
            game_rst_q   <= 1'b1;
            flash_q      <= 1'b0;
        end else begin
            hit_q        <= hit_d;
            frame_cnt_q  <= frame_cnt_d;
            lives_q      <= lives_d;
            best_q       <= best_d;
            move_pulse_q <= move_pulse_d;
            game_rst_q   <= game_rst_d;
            flash_q      <= flash_d;
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign best_score = best_q;
    assign move_pulse = move_pulse_q;
    assign game_rst   = game_rst_q;
    assign flash      = flash_q;

endmodule
